// File: rtl/ws2812b_bit_encoder.sv
// WS2812B NRZ serialiser: shifts 24-bit GRB words out MSB first and emits the strip latch period on request.
// Optional one-word hold register for gapless streaming when WS2812B_PREFETCH_EN is defined.
module ws2812b_bit_encoder #(
    parameter int CLOCK_MHZ = 64,
    parameter int T0H_NS    = 400,
    parameter int T1H_NS    = 800,
    parameter int TBIT_NS   = 1250,
    parameter int TRESET_US = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] data_in,
    input  logic        valid,
    input  logic        latch,
    output logic        ready,
    output logic        busy,
    output logic        led
);

    localparam int T0H_CYC    = (CLOCK_MHZ * T0H_NS) / 1000;
    localparam int T1H_CYC    = (CLOCK_MHZ * T1H_NS) / 1000;
    localparam int TBIT_CYC   = (CLOCK_MHZ * TBIT_NS) / 1000;
    localparam int TRESET_CYC = CLOCK_MHZ * TRESET_US;
    localparam int CNT_MAX    = (TRESET_CYC > TBIT_CYC) ? TRESET_CYC : TBIT_CYC;
    localparam int CW         = $clog2(CNT_MAX);

    generate
        if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_timing
            $error("ws2812b_bit_encoder: requires 0 < T0H < T1H < TBIT in clock cycles");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

    state_t         state_reg, state_next;
    logic           led_reg, led_next;
    logic           ready_reg, ready_next;
    logic [23:0]    shift_reg, shift_next;
    logic [4:0]     bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]  cyc_cnt_reg, cyc_cnt_next;
    logic           latch_reg, latch_next;
    logic           accept;
    logic           start_word;
    logic [CW-1:0]  thigh_end;
`ifdef WS2812B_PREFETCH_EN
    logic [23:0]    hold_data_reg, hold_data_next;
    logic           hold_latch_reg, hold_latch_next;
    logic           hold_full_reg, hold_full_next;
    logic           from_hold;
`endif

    assign accept = valid && ready_reg;
    assign ready  = ready_reg;
    assign led    = led_reg;
    assign busy   = (state_reg != IDLE);

    // cyc_cnt runs across the whole bit, so HIGH ends at THIGH-1 and LOW at TBIT-1
    assign thigh_end = shift_reg[23] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            led_reg        <= 1'b0;
            ready_reg      <= 1'b0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            cyc_cnt_reg    <= '0;
            latch_reg      <= 1'b0;
`ifdef WS2812B_PREFETCH_EN
            hold_data_reg  <= '0;
            hold_latch_reg <= 1'b0;
            hold_full_reg  <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            led_reg        <= led_next;
            ready_reg      <= ready_next;
            shift_reg      <= shift_next;
            bit_cnt_reg    <= bit_cnt_next;
            cyc_cnt_reg    <= cyc_cnt_next;
            latch_reg      <= latch_next;
`ifdef WS2812B_PREFETCH_EN
            hold_data_reg  <= hold_data_next;
            hold_latch_reg <= hold_latch_next;
            hold_full_reg  <= hold_full_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        led_next     = led_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        cyc_cnt_next = cyc_cnt_reg;
        latch_next   = latch_reg;
        start_word   = 1'b0;
`ifdef WS2812B_PREFETCH_EN
        hold_data_next  = hold_data_reg;
        hold_latch_next = hold_latch_reg;
        hold_full_next  = hold_full_reg;
        from_hold       = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
`ifdef WS2812B_PREFETCH_EN
                if (hold_full_reg) begin
                    start_word = 1'b1;
                    from_hold  = 1'b1;
                end else if (accept) begin
                    start_word = 1'b1;
                end
`else
                if (accept) start_word = 1'b1;
`endif
            end
            HIGH: begin
                cyc_cnt_next = cyc_cnt_reg + 1'b1;
                if (cyc_cnt_reg == thigh_end) begin
                    state_next = LOW;
                    led_next   = 1'b0;
                end
            end
            LOW: begin
                cyc_cnt_next = cyc_cnt_reg + 1'b1;
                if (cyc_cnt_reg == CW'(TBIT_CYC - 1)) begin
                    if (bit_cnt_reg != 5'd23) begin
                        shift_next   = {shift_reg[22:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        cyc_cnt_next = '0;
                        led_next     = 1'b1;
                        state_next   = HIGH;
                    end else if (latch_reg) begin
                        cyc_cnt_next = '0;
                        state_next   = LATCH;
                    end else begin
`ifdef WS2812B_PREFETCH_EN
                        if (hold_full_reg) begin
                            start_word = 1'b1;
                            from_hold  = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
`else
                        state_next = IDLE;
`endif
                    end
                end
            end
            LATCH: begin
                cyc_cnt_next = cyc_cnt_reg + 1'b1;
                if (cyc_cnt_reg == CW'(TRESET_CYC - 1)) begin
`ifdef WS2812B_PREFETCH_EN
                    if (hold_full_reg) begin
                        start_word = 1'b1;
                        from_hold  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
`else
                    state_next = IDLE;
`endif
                end
            end
            default: state_next = IDLE;
        endcase

        // Every word begins with the rising edge of bit 23 on the very next cycle
        if (start_word) begin
            state_next   = HIGH;
            led_next     = 1'b1;
            bit_cnt_next = '0;
            cyc_cnt_next = '0;
`ifdef WS2812B_PREFETCH_EN
            if (from_hold) begin
                shift_next = hold_data_reg;
                latch_next = hold_latch_reg;
            end else begin
                shift_next = data_in;
                latch_next = latch;
            end
`else
            shift_next = data_in;
            latch_next = latch;
`endif
        end

`ifdef WS2812B_PREFETCH_EN
        if (from_hold) hold_full_next = 1'b0;
        // Accept in IDLE goes straight to the shifter; anywhere else it parks in the hold register
        if (accept && state_reg != IDLE) begin
            hold_data_next  = data_in;
            hold_latch_next = latch;
            hold_full_next  = 1'b1;
        end
        ready_next = !hold_full_next;
`else
        ready_next = (state_next == IDLE);
`endif
    end

endmodule
